// File: rtl/alu_op_controller.sv
// alu_op_controller: one-at-a-time sequencer in front of the 32-bit ALU.
// Accepts an operation over valid/ready, holds the ALU select/operands for
// the operation's latency, then presents the registered result over a
// valid/ready response port and counts completed responses.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | ready for a request; ALU lines keep their last values
// EXEC    | ALU lines held; wait counter runs down to its terminal count
// RESP    | response presented; held until the consumer takes it
module alu_op_controller #(
    parameter int MOD_CYCLES = 34,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    output logic [2:0]       alu_sel,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    input  logic [31:0]      alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [2:0]       rsp_op,
    output logic             rsp_divzero,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [2:0] OP_MOD   = 3'd7;
    localparam logic [7:0] MOD_LOAD = 8'(MOD_CYCLES);
    localparam logic [7:0] ONE_LOAD = 8'd1;

    logic [1:0] state;
    logic [7:0] wait_cnt;
    logic [7:0] wait_load;
    logic       accept;
    logic       wait_done;
    logic       handshake;
    logic       div_zero;

    assign accept    = (state == ST_IDLE) && req_valid;
    assign wait_done = (state == ST_EXEC) && (wait_cnt == 8'd1);
    assign handshake = (state == ST_RESP) && rsp_ready;

    // Divide-by-zero is judged on the latched operands, not the live request.
    assign div_zero = (alu_sel == OP_MOD) && (alu_b == 32'd0);

    // Only a MOD with a real divisor waits on the clocked unit; a zero
    // divisor is answered immediately with a forced result.
    always_comb begin
        wait_load = ONE_LOAD;
        if ((req_op == OP_MOD) && (req_b != 32'd0)) begin
            wait_load = MOD_LOAD;
        end
    end

    // Sequencing FSM: IDLE -> EXEC on accept, EXEC -> RESP at terminal count,
    // RESP -> IDLE on the response handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept)    state <= ST_EXEC;
                ST_EXEC: if (wait_done) state <= ST_RESP;
                ST_RESP: if (handshake) state <= ST_IDLE;
                default:                state <= ST_IDLE;
            endcase
        end
    end

    // Latency timer: loaded on accept, counts down in EXEC, cleared on exit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 8'd0;
        end else if (accept) begin
            wait_cnt <= wait_load;
        end else if (wait_done) begin
            wait_cnt <= 8'd0;
        end else if (state == ST_EXEC) begin
            wait_cnt <= wait_cnt - 8'd1;
        end
    end

    // ALU drive lines change only on an accept edge and are otherwise held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_sel <= 3'd0;
            alu_a   <= 32'd0;
            alu_b   <= 32'd0;
        end else if (accept) begin
            alu_sel <= req_op;
            alu_a   <= req_a;
            alu_b   <= req_b;
        end
    end

    // Response capture at terminal count; held through RESP until taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_result  <= 32'd0;
            rsp_op      <= 3'd0;
            rsp_divzero <= 1'b0;
        end else if (wait_done) begin
            rsp_result  <= div_zero ? 32'd0 : alu_result;
            rsp_op      <= alu_sel;
            rsp_divzero <= div_zero;
        end
    end

    // Completed-response counter, free-running wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_count <= '0;
        end else if (handshake) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_op_controller.sv
// Testbench for alu_op_controller: emulates the ALU (including a clocked MOD
// unit that only settles after MOD_CYCLES edges) and checks each response
// against a reference computed from the operation rules.
module tb_alu_op_controller;

    localparam int MOD_CYCLES = 34;
    localparam int CNT_W      = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [2:0]       alu_sel;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [31:0]      alu_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic [2:0]       rsp_op;
    logic             rsp_divzero;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    int checks = 0;
    int errors = 0;
    logic [CNT_W-1:0] exp_count;

    alu_op_controller #(.MOD_CYCLES(MOD_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_op(rsp_op), .rsp_divzero(rsp_divzero), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // ALU emulation: MOD output is garbage until operands have been stable long
    // enough that the sample at edge E0+MOD_CYCLES is the first settled one.
    logic [66:0] last_ops = '1;
    int          stable_edges = 0;

    always @(posedge clk) begin
        if ({alu_sel, alu_a, alu_b} != last_ops) begin
            last_ops     <= {alu_sel, alu_a, alu_b};
            stable_edges <= 0;
        end else if (stable_edges < 1000) begin
            stable_edges <= stable_edges + 1;
        end
    end

    always_comb begin
        alu_result = 32'd0;
        case (alu_sel)
            3'd0: alu_result = alu_a & alu_b;
            3'd1: alu_result = alu_a | alu_b;
            3'd2: alu_result = alu_a ^ alu_b;
            3'd3: alu_result = ~(alu_a | alu_b);
            3'd4: alu_result = (alu_a < alu_b) ? 32'd1 : 32'd0;
            3'd5: alu_result = alu_a + alu_b;
            3'd6: alu_result = alu_a - alu_b;
            default: begin
                if (alu_b == 32'd0)
                    alu_result = 32'hBAD0_BAD0;
                else if (({alu_sel, alu_a, alu_b} == last_ops) && (stable_edges >= MOD_CYCLES - 2))
                    alu_result = alu_a % alu_b;
                else
                    alu_result = 32'hDEAD_BEEF;
            end
        endcase
    end

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: ref_result = a & b;
            3'd1: ref_result = a | b;
            3'd2: ref_result = a ^ b;
            3'd3: ref_result = ~(a | b);
            3'd4: ref_result = (a < b) ? 32'd1 : 32'd0;
            3'd5: ref_result = a + b;
            3'd6: ref_result = a - b;
            default: ref_result = (b == 32'd0) ? 32'd0 : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] b);
        ref_latency = ((op == 3'd7) && (b != 32'd0)) ? MOD_CYCLES : 1;
    endfunction

    // Issues one request from IDLE and returns once rsp_valid is seen (or the
    // bound expires), with edges counted from the accept edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        exp_count = exp_count + 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = 3'd0; req_a = 32'd0; req_b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        exp_count = '0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0b want 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
        checks++; if (op_count !== '0) begin errors++; $display("FAIL reset_op_count got %0d want 0", op_count); end
        checks++; if ({busy, rsp_divzero, rsp_op, rsp_result} !== 37'd0) begin errors++;
            $display("FAIL reset_rsp_outputs got busy=%0b dz=%0b op=%0d res=%h want all 0", busy, rsp_divzero, rsp_op, rsp_result); end
        checks++; if ({alu_sel, alu_a, alu_b} !== 67'd0) begin errors++;
            $display("FAIL reset_alu_lines got sel=%0d a=%h b=%h want all 0", alu_sel, alu_a, alu_b); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_add();
        int lat;
        issue(3'd5, 32'd7, 32'd5, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got %0d want 1", lat); end
        checks++; if (rsp_result !== 32'd12) begin errors++; $display("FAIL add_result got %h want 0000000c", rsp_result); end
        checks++; if (rsp_op !== 3'd5) begin errors++; $display("FAIL add_rsp_op got %0d want 5", rsp_op); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL add_busy got %0b want 1", busy); end
        handshake();
        checks++; if (op_count !== exp_count) begin errors++; $display("FAIL add_op_count got %0d want %0d", op_count, exp_count); end
        checks++; if ({rsp_valid, req_ready, busy} !== 3'b010) begin errors++;
            $display("FAIL add_after_handshake got valid=%0b ready=%0b busy=%0b want 0 1 0", rsp_valid, req_ready, busy); end
    endtask

    task automatic test_sub_hold();
        int lat;
        logic [31:0] exp_res;
        exp_res = ref_result(3'd6, 32'd3, 32'd5);
        issue(3'd6, 32'd3, 32'd5, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL sub_latency got %0d want 1", lat); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_op = 3'($urandom_range(0, 5)); req_a = $urandom; req_b = $urandom;
            @(posedge clk);
            #1;
            checks++; if (rsp_result !== exp_res || rsp_valid !== 1'b1) begin errors++;
                $display("FAIL sub_hold_result cycle %0d got valid=%0b res=%h want 1 %h", i, rsp_valid, rsp_result, exp_res); end
            checks++; if (req_ready !== 1'b0 || alu_sel !== 3'd6 || alu_a !== 32'd3) begin errors++;
                $display("FAIL sub_hold_ignore cycle %0d got ready=%0b sel=%0d a=%h want 0 6 3", i, req_ready, alu_sel, alu_a); end
        end
        @(negedge clk);
        req_valid = 1'b0;
        handshake();
        checks++; if (op_count !== exp_count) begin errors++; $display("FAIL sub_op_count got %0d want %0d", op_count, exp_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sub_idle_after got busy=%0b want 0", busy); end
    endtask

    task automatic test_mod();
        int lat;
        issue(3'd7, 32'd100, 32'd7, lat);
        checks++; if (lat !== MOD_CYCLES) begin errors++; $display("FAIL mod_latency got %0d want %0d", lat, MOD_CYCLES); end
        checks++; if (rsp_result !== 32'd2 || rsp_divzero !== 1'b0 || rsp_op !== 3'd7) begin errors++;
            $display("FAIL mod_result got res=%h dz=%0b op=%0d want 2 0 7", rsp_result, rsp_divzero, rsp_op); end
        handshake();
        issue(3'd7, 32'd9, 32'd0, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL modz_latency got %0d want 1", lat); end
        checks++; if (rsp_result !== 32'd0 || rsp_divzero !== 1'b1) begin errors++;
            $display("FAIL modz_result got res=%h dz=%0b want 0 1", rsp_result, rsp_divzero); end
        handshake();
        checks++; if (op_count !== exp_count) begin errors++; $display("FAIL mod_op_count got %0d want %0d", op_count, exp_count); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        longint acc_t [5];
        int n;
        a = 32'hF0F0_F0F0; b = 32'h0FF0_0FF0;
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_op = 3'd0; req_a = a; req_b = b;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
            @(posedge clk);
            acc_t[i] = $time;
            #1;
            if (i < 4) req_op = 3'(i + 1); else req_valid = 1'b0;
            n = 0;
            while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
            checks++; if (rsp_result !== ref_result(3'(i), a, b) || rsp_op !== 3'(i)) begin errors++;
                $display("FAIL b2b_result op %0d got res=%h op=%0d want %h", i, rsp_result, rsp_op, ref_result(3'(i), a, b)); end
            exp_count = exp_count + 1'b1;
            if (i > 0) begin
                checks++; if (acc_t[i] - acc_t[i-1] != 30) begin errors++;
                    $display("FAIL b2b_spacing op %0d got %0d ns want 30 ns", i, acc_t[i] - acc_t[i-1]); end
            end
        end
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        checks++; if (op_count !== exp_count || rsp_valid !== 1'b0) begin errors++;
            $display("FAIL b2b_op_count got %0d valid=%0b want %0d 0", op_count, rsp_valid, exp_count); end
    endtask

    task automatic test_reset_mid_mod();
        int lat;
        bit seen;
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd7; req_a = $urandom; req_b = 32'd13;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        exp_count = '0;
        checks++; if ({req_ready, rsp_valid, busy} !== 3'b100) begin errors++;
            $display("FAIL midreset_flags got ready=%0b valid=%0b busy=%0b want 1 0 0", req_ready, rsp_valid, busy); end
        checks++; if (op_count !== '0 || alu_sel !== 3'd0 || alu_b !== 32'd0) begin errors++;
            $display("FAIL midreset_regs got cnt=%0d sel=%0d b=%h want 0 0 0", op_count, alu_sel, alu_b); end
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (50) begin @(posedge clk); #1; if (rsp_valid) seen = 1'b1; end
        checks++; if (seen) begin errors++; $display("FAIL midreset_no_response got rsp_valid=1 want 0"); end
        issue(3'd5, 32'd1, 32'd1, lat);
        checks++; if (rsp_result !== 32'd2 || lat !== 1) begin errors++;
            $display("FAIL midreset_add got res=%h lat=%0d want 2 1", rsp_result, lat); end
        handshake();
        checks++; if (op_count !== exp_count) begin errors++; $display("FAIL midreset_op_count got %0d want %0d", op_count, exp_count); end
    endtask

    task automatic test_random_wrap();
        int lat;
        logic [2:0] op;
        logic [31:0] a, b;
        test_reset();
        for (int i = 0; i < 17; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if (op == 3'd7 && $urandom_range(0, 3) == 0) b = 32'd0;
            if (op == 3'd4 && $urandom_range(0, 1) == 0) b = a + 32'($urandom_range(1, 9));
            issue(op, a, b, lat);
            checks++; if (lat !== ref_latency(op, b)) begin errors++;
                $display("FAIL rand_latency #%0d op %0d got %0d want %0d", i, op, lat, ref_latency(op, b)); end
            checks++; if (rsp_result !== ref_result(op, a, b) || rsp_op !== op) begin errors++;
                $display("FAIL rand_result #%0d op %0d got res=%h op=%0d want %h", i, op, rsp_result, rsp_op, ref_result(op, a, b)); end
            checks++; if (rsp_divzero !== (op == 3'd7 && b == 32'd0)) begin errors++;
                $display("FAIL rand_divzero #%0d op %0d got %0b", i, op, rsp_divzero); end
            handshake();
        end
        checks++; if (op_count !== exp_count || op_count !== 4'd1) begin errors++;
            $display("FAIL wrap_op_count got %0d want 1", op_count); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_hold();
        test_mod();
        test_reset();
        test_back_to_back();
        test_reset_mid_mod();
        test_random_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_op_controller.md
Name: alu_op_controller

Overview:
Sequencer placed in front of the 32-bit ALU (AND/OR/XOR/NOR/LT/ADD/SUB/MOD, 3-bit select). It accepts one operation at a time over a valid/ready request port and drives the ALU select and operand lines. It waits the operation's latency: one cycle for the combinational ops, a programmable cycle count for the clocked MOD unit. It then returns the registered result over a valid/ready response port with a completion counter.

Parameters:
MOD_CYCLES, 34, clock edges the MOD unit needs from operand change to a stable result; legal range 1..255.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  controller can accept a request.
req_op  input  3  0 AND, 1 OR, 2 XOR, 3 NOR, 4 LT, 5 ADD, 6 SUB, 7 MOD.
req_a  input  32  operand A.
req_b  input  32  operand B.
alu_sel  output  3  to ALU select.
alu_a  output  32  to ALU operand A.
alu_b  output  32  to ALU operand B.
alu_result  input  32  from ALU result.
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer takes response.
rsp_result  output  32  registered ALU result.
rsp_op  output  3  opcode of this response.
rsp_divzero  output  1  MOD issued with B = 0.
busy  output  1  state != IDLE.
op_count  output  CNT_W  completed responses, wraps.

Behaviour:
- Reset (async, any state): state IDLE, req_ready 1, every other output 0, wait counter 0. Any in-flight op is discarded and no response is produced for it.
- States: IDLE, EXEC, RESP.
- IDLE: req_ready = 1.
  - On req_valid at an edge (accept edge E0): latch req_op/req_a/req_b into alu_sel/alu_a/alu_b, load the wait counter, go to EXEC.
  - Wait counter load value: 1 for ops 0-6; MOD_CYCLES for op 7 with B != 0; 1 for op 7 with B = 0.
- EXEC: req_ready = 0. alu_* are held stable. The counter decrements each edge.
  - At the edge where the counter is 1, capture alu_result into rsp_result, set rsp_op, set rsp_divzero, go to RESP.
  - For MOD with B = 0: rsp_result is forced to 0 and rsp_divzero = 1.
  - Latency: ops 0-6 capture at E0+1; MOD captures at E0+MOD_CYCLES. rsp_valid is high from the cycle after capture.
- RESP: rsp_valid = 1. rsp_result, rsp_op and rsp_divzero are held until the rsp_ready handshake edge.
  - On that edge: rsp_valid drops, op_count += 1 (modulo 2^CNT_W), state returns to IDLE.
  - No request is accepted in the handshake cycle. The minimum issue interval is therefore 3 cycles for ops 0-6.
- alu_sel/alu_a/alu_b keep their last values in IDLE and RESP. They change only on an accept edge.
- Request inputs are ignored outside IDLE. rsp_ready is ignored outside RESP.
- rsp_divzero is 0 for all ops other than MOD.
- busy = (state != IDLE).
- op_count wraps from all-ones to 0 with no flag.

Test Plan:
- After reset: req_ready = 1, rsp_valid = 0, op_count = 0. ADD A=7, B=5 -> rsp_valid 2 cycles after accept, rsp_result 12, rsp_op 5.
- SUB A=3, B=5 with rsp_ready held low 10 cycles -> rsp_result 0xFFFFFFFE held stable, req_ready = 0 throughout. A new req_valid during the hold is ignored.
- MOD A=100, B=7 with MOD_CYCLES=34 -> rsp_valid is first high 35 cycles after accept, rsp_result 2, rsp_divzero 0. MOD A=9, B=0 -> rsp_result 0, rsp_divzero 1, latency 2.
- Back-to-back AND, OR, XOR, NOR, LT with rsp_ready tied high, operands A=0xF0F0F0F0, B=0x0FF00FF0:
  - AND 0x00F000F0, OR 0xFFF0FFF0, XOR 0xFF00FF00, NOR 0x000F000F.
  - LT (unsigned) A>B -> 0.
  - op_count 5; accepts spaced by 3 cycles.
- Reset asserted mid-MOD (cycle 10 of 34) -> outputs immediately return to reset values, no response appears, op_count 0. A following ADD 1+1 returns 2.
- CNT_W=4, 17 operations -> op_count wraps to 1.
